// File: rtl/mips_sort_result_drain.sv
// Purpose: snapshot the eight sort-core result words, check their signed order in hardware, then stream them out.
// Latency: sorted_ok/chk_valid and the first m_valid come 7 cycles after the capture edge; 8 more beats to drain at full rate.
// Backpressure: m_ready low holds the current word indefinitely; a done_in that arrives while busy is dropped and flagged as overrun.
module mips_sort_result_drain #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              done_in,
    input  logic [DATA_W-1:0] res0,
    input  logic [DATA_W-1:0] res1,
    input  logic [DATA_W-1:0] res2,
    input  logic [DATA_W-1:0] res3,
    input  logic [DATA_W-1:0] res4,
    input  logic [DATA_W-1:0] res5,
    input  logic [DATA_W-1:0] res6,
    input  logic [DATA_W-1:0] res7,
    input  logic [31:0]       n_inst_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [2:0]        m_idx,
    output logic              m_last,
    output logic              sorted_ok,
    output logic              chk_valid,
    output logic [31:0]       n_inst_lat,
    output logic              busy,
    output logic              overrun,
    output logic [CNT_W-1:0]  drain_cnt
);

    typedef enum logic [1:0] {IDLE, CHECK, STREAM} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] res_buf [8];
    logic [2:0]        idx;
    logic [2:0]        idx_inc;
    logic              ok_tmp;
    logic              pair_ok;

    assign idx_inc = idx + 3'd1;
    // idx never exceeds 6 in CHECK, so idx_inc never wraps during a compare
    assign pair_ok = $signed(res_buf[idx]) <= $signed(res_buf[idx_inc]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stream outputs are decoded only from state/idx/res_buf, never from m_ready
    always_comb begin
        state_nxt = state;
        m_valid   = 1'b0;
        m_data    = '0;
        m_idx     = '0;
        m_last    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (done_in) state_nxt = CHECK;
            end
            CHECK: begin
                if (idx == 3'd6) state_nxt = STREAM;
            end
            STREAM: begin
                m_valid = 1'b1;
                m_data  = res_buf[idx];
                m_idx   = idx;
                m_last  = (idx == 3'd7);
                if (m_ready && idx == 3'd7) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 8; k++) res_buf[k] <= '0;
            idx        <= '0;
            ok_tmp     <= 1'b0;
            sorted_ok  <= 1'b0;
            chk_valid  <= 1'b0;
            n_inst_lat <= '0;
            overrun    <= 1'b0;
            drain_cnt  <= '0;
        end else begin
            chk_valid <= 1'b0;
            if (done_in && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (done_in) begin
                        res_buf[0] <= res0;
                        res_buf[1] <= res1;
                        res_buf[2] <= res2;
                        res_buf[3] <= res3;
                        res_buf[4] <= res4;
                        res_buf[5] <= res5;
                        res_buf[6] <= res6;
                        res_buf[7] <= res7;
                        n_inst_lat <= n_inst_in;
                        idx        <= '0;
                        ok_tmp     <= 1'b1;
                    end
                end
                CHECK: begin
                    ok_tmp <= ok_tmp & pair_ok;
                    if (idx == 3'd6) begin
                        sorted_ok <= ok_tmp & pair_ok;
                        chk_valid <= 1'b1;
                        idx       <= '0;
                    end else begin
                        idx <= idx_inc;
                    end
                end
                STREAM: begin
                    if (m_ready) begin
                        if (idx == 3'd7) begin
                            idx       <= '0;
                            drain_cnt <= drain_cnt + CNT_W'(1);
                        end else begin
                            idx <= idx_inc;
                        end
                    end
                end
                default: idx <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_sort_result_drain.sv
// Randomized bench for mips_sort_result_drain with a set-level reference model (order rule, stream order, counters).
module tb_mips_sort_result_drain;

    logic        clk = 1'b0;
    logic        rstn;
    logic        done_in;
    logic [31:0] res [8];
    logic [31:0] n_inst_in;
    logic        m_valid, m_ready, m_last, sorted_ok, chk_valid, busy, overrun;
    logic [31:0] m_data, n_inst_lat;
    logic [2:0]  m_idx;
    logic [15:0] drain_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] cur_w [8];
    int          exp_drain;
    logic        exp_ovr;

    always #5 clk = ~clk;

    mips_sort_result_drain #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .done_in(done_in),
        .res0(res[0]), .res1(res[1]), .res2(res[2]), .res3(res[3]),
        .res4(res[4]), .res5(res[5]), .res6(res[6]), .res7(res[7]),
        .n_inst_in(n_inst_in), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
        .sorted_ok(sorted_ok), .chk_valid(chk_valid), .n_inst_lat(n_inst_lat),
        .busy(busy), .overrun(overrun), .drain_cnt(drain_cnt)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a set is ordered when no word is signed-greater than its successor
    function automatic logic model_sorted();
        for (int i = 0; i < 7; i++)
            if ($signed(cur_w[i]) > $signed(cur_w[i+1])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic sort_cur();
        logic [31:0] t;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if ($signed(cur_w[j]) > $signed(cur_w[j+1])) begin
                    t = cur_w[j]; cur_w[j] = cur_w[j+1]; cur_w[j+1] = t;
                end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, "_m_valid"}, m_valid, 0);
        chk_eq({tag, "_m_data"}, m_data, 0);
        chk_eq({tag, "_m_idx"}, m_idx, 0);
        chk_eq({tag, "_m_last"}, m_last, 0);
        chk_eq({tag, "_sorted_ok"}, sorted_ok, 0);
        chk_eq({tag, "_chk_valid"}, chk_valid, 0);
        chk_eq({tag, "_n_inst_lat"}, n_inst_lat, 0);
        chk_eq({tag, "_busy"}, busy, 0);
        chk_eq({tag, "_overrun"}, overrun, 0);
        chk_eq({tag, "_drain_cnt"}, drain_cnt, 0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the last beat is accepted
    task automatic drain_set(input logic [31:0] ninst, input int mode, input int dup_at);
        int   cyc;
        int   nxt;
        int   pulses;
        logic exp_ok;
        exp_ok = model_sorted();
        for (int i = 0; i < 8; i++) res[i] = cur_w[i];
        n_inst_in = ninst;
        done_in   = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        cyc = 0; nxt = 0; pulses = 0;
        while (nxt < 8 && cyc < 400) begin
            done_in = (cyc == dup_at);
            if (cyc == dup_at) begin
                for (int i = 0; i < 8; i++) res[i] = ~cur_w[i];
                n_inst_in = ~ninst;
                exp_ovr   = 1'b1;
            end
            m_ready = ready_for(mode, cyc);
            if (chk_valid) pulses++;
            if (cyc < 7) chk_eq("check_phase", {busy, m_valid}, 2'b10);
            if (cyc == 7) begin
                chk_eq("chk_valid_at_7", chk_valid, 1);
                chk_eq("sorted_ok", sorted_ok, exp_ok);
            end
            chk_eq("drain_cnt_mid", drain_cnt, 64'(exp_drain));
            if (m_valid) begin
                chk_eq("m_idx", m_idx, 64'(nxt));
                chk_eq("m_data", m_data, cur_w[nxt]);
                chk_eq("m_last", m_last, nxt == 7);
                if (m_ready) nxt++;
            end
            @(negedge clk);
            cyc++;
        end
        done_in = 1'b0;
        if (nxt < 8) chk_eq("timeout_words", 64'(nxt), 8);
        exp_drain = (exp_drain + 1) % 65536;
        chk_eq("chk_pulses", 64'(pulses), 1);
        chk_eq("chk_valid_after", chk_valid, 0);
        chk_eq("drain_cnt", drain_cnt, 64'(exp_drain));
        chk_eq("busy_after", busy, 0);
        chk_eq("m_valid_after", m_valid, 0);
        chk_eq("n_inst_lat", n_inst_lat, ninst);
        chk_eq("sorted_ok_hold", sorted_ok, exp_ok);
        chk_eq("overrun", overrun, exp_ovr);
        if (mode == 0) chk_eq("drain_latency", 64'(cyc), 15);
    endtask

    initial begin
        int guard;
        int dup;
        rstn = 1'b0; done_in = 1'b0; m_ready = 1'b0; n_inst_in = '0;
        for (int i = 0; i < 8; i++) res[i] = '0;
        exp_drain = 0; exp_ovr = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Ascending set, full rate
        for (int i = 0; i < 8; i++) cur_w[i] = 32'(i + 1);
        drain_set(32'd500, 0, -1);

        // Signed ordering, issued the cycle after busy falls
        cur_w[0] = 32'hFFFF_FFFF; cur_w[1] = 0; cur_w[2] = 1; cur_w[3] = 1;
        cur_w[4] = 2; cur_w[5] = 3; cur_w[6] = 4; cur_w[7] = 32'h7FFF_FFFF;
        drain_set(32'd77, 0, -1);

        // Unsorted set under a 1,0,0 backpressure pattern
        for (int i = 0; i < 8; i++) cur_w[i] = 32'(i + 4);
        cur_w[0] = 5; cur_w[1] = 4;
        drain_set(32'd1234, 1, -1);

        // Second done_in three cycles after capture
        for (int i = 0; i < 8; i++) cur_w[i] = 32'(100 * i);
        drain_set(32'd9, 0, 2);

        // Reset while word 4 is on the output
        for (int i = 0; i < 8; i++) res[i] = 32'(i);
        n_inst_in = 32'd42; m_ready = 1'b1; done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        guard = 0;
        while (!(m_valid && m_idx == 3'd4) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk_eq("reach_idx4", 64'(guard < 50), 1);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rstn = 1'b1;
        exp_drain = 0; exp_ovr = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) cur_w[i] = 32'h10;
        drain_set(32'd3, 0, -1);

        // Random sets: mixed order, ready patterns and stray done_in pulses
        for (int s = 0; s < 14; s++) begin
            for (int i = 0; i < 8; i++)
                cur_w[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 6)) - 32'd3;
            if ($urandom_range(0, 1) == 1) sort_cur();
            dup = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            drain_set($urandom, int'($urandom_range(0, 2)), dup);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
